alu_exec_unit: RTL and testbench

- Downstream execute stage of the 8-bit ALU datapath. Consumes the A/B operand registers plus an opcode and a start strobe.
- Single-cycle ops: ADD, SUB, AND, OR, XOR, NOT.
- Multi-cycle ops: shift-add MUL and restoring DIV, one iteration per clock.
- Drives result registers, flags, and a busy/done handshake to the sequencer.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_exec_unit_if.sv | 27 ++
 rtl/alu_muldiv_iter.sv | 66 ++++++
 rtl/alu_exec_unit.sv | 152 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the ALU execute stage.
// No logic; types and widths only.
// Imported by the interface, iterator and top.
package alu_pkg;
    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_NOT_A = 3'b101,
        OP_MUL   = 3'b110,
        OP_DIV   = 3'b111
    } op_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_e;
endpackage

// File: rtl/alu_exec_unit_if.sv
// Sequencer <-> execute-stage bundle: operands/opcode/start in, results/flags/handshake out.
// Pure wiring, no latency.
// Flow control is start/busy/done; start is ignored while busy.
interface alu_exec_unit_if #(parameter int WIDTH = 8);
    logic                      start;
    logic [alu_pkg::OP_W-1:0]  op;
    logic [WIDTH-1:0]          a;
    logic [WIDTH-1:0]          b;
    logic [WIDTH-1:0]          result_lo;
    logic [WIDTH-1:0]          result_hi;
    logic                      carry;
    logic                      overflow;
    logic                      zero;
    logic                      div_by_zero;
    logic                      busy;
    logic                      done;

    modport master (
        output start, op, a, b,
        input  result_lo, result_hi, carry, overflow, zero, div_by_zero, busy, done
    );

    modport slave (
        input  start, op, a, b,
        output result_lo, result_hi, carry, overflow, zero, div_by_zero, busy, done
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Shift-add multiply / restoring divide datapath, one iteration per step.
// WIDTH steps after load; hi/lo show the value the current step produces.
// No backpressure; the owner gates step.
module alu_muldiv_iter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;
    logic             mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;

    // MUL: hi_q is the upper partial, lo_q the multiplier shifting out.
    // DIV: hi_q is the remainder, lo_q the dividend shifting into quotient.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        if (mode_q) begin
            hi = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
            lo = {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
        end else begin
            hi = mul_sum[WIDTH:1];
            lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign last = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            mode_q <= 1'b0;
            cnt_q  <= '0;
        end else if (load) begin
            hi_q   <= '0;
            lo_q   <= div_mode ? a : b;
            opnd_q <= div_mode ? b : a;
            mode_q <= div_mode;
            cnt_q  <= '0;
        end else if (step) begin
            hi_q <= hi;
            lo_q <= lo;
            if (!last) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// 8-bit ALU execute stage: single-cycle logic/arith plus iterative MUL/DIV.
// done one cycle after start for single-cycle ops and DIV by zero, WIDTH+1 cycles for MUL/DIV.
// start is ignored while busy; start during the done cycle is accepted.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    alu_exec_unit_if.slave   bus
);
    state_e           state;
    op_e              op_in;
    op_e              op_q;
    logic             multi_req;
    logic             it_last;
    logic [WIDTH-1:0] it_hi;
    logic [WIDTH-1:0] it_lo;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_v;

    logic [WIDTH-1:0] result_lo_q;
    logic [WIDTH-1:0] result_hi_q;
    logic             carry_q;
    logic             overflow_q;
    logic             zero_q;
    logic             dbz_q;
    logic             busy_q;
    logic             done_q;

    assign op_in     = op_e'(bus.op);
    assign multi_req = (op_in == OP_MUL) || ((op_in == OP_DIV) && (bus.b != '0));

    always_comb begin
        sum_w  = '0;
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (op_in)
            OP_ADD: begin
                sum_w  = {1'b0, bus.a} + {1'b0, bus.b};
                sc_res = sum_w[WIDTH-1:0];
                sc_c   = sum_w[WIDTH];
                sc_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sc_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                // Top bit of the extended difference is the borrow.
                sum_w  = {1'b0, bus.a} - {1'b0, bus.b};
                sc_res = sum_w[WIDTH-1:0];
                sc_c   = sum_w[WIDTH];
                sc_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sc_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:   sc_res = bus.a & bus.b;
            OP_OR:    sc_res = bus.a | bus.b;
            OP_XOR:   sc_res = bus.a ^ bus.b;
            OP_NOT_A: sc_res = ~bus.a;
            default:  sc_res = '0;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk      (clk),
        .reset    (reset),
        .load     ((state == IDLE) && bus.start && multi_req),
        .step     (state == ITER),
        .div_mode (op_in == OP_DIV),
        .a        (bus.a),
        .b        (bus.b),
        .last     (it_last),
        .hi       (it_hi),
        .lo       (it_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= OP_ADD;
            result_lo_q <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q <= op_in;
                        if (multi_req) begin
                            state  <= ITER;
                            busy_q <= 1'b1;
                        end else if (op_in == OP_DIV) begin
                            result_lo_q <= '1;
                            result_hi_q <= bus.a;
                            carry_q     <= 1'b0;
                            overflow_q  <= 1'b0;
                            zero_q      <= 1'b0;
                            dbz_q       <= 1'b1;
                            done_q      <= 1'b1;
                        end else begin
                            result_lo_q <= sc_res;
                            result_hi_q <= '0;
                            carry_q     <= sc_c;
                            overflow_q  <= sc_v;
                            zero_q      <= (sc_res == '0);
                            dbz_q       <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    if (it_last) begin
                        state       <= IDLE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        result_lo_q <= it_lo;
                        result_hi_q <= it_hi;
                        carry_q     <= 1'b0;
                        dbz_q       <= 1'b0;
                        if (op_q == OP_MUL) begin
                            overflow_q <= (it_hi != '0);
                            zero_q     <= ({it_hi, it_lo} == '0);
                        end else begin
                            overflow_q <= 1'b0;
                            zero_q     <= (it_lo == '0);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result_lo   = result_lo_q;
    assign bus.result_hi   = result_hi_q;
    assign bus.carry       = carry_q;
    assign bus.overflow    = overflow_q;
    assign bus.zero        = zero_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboarded bench for alu_exec_unit: directed corner cases then random ops,
// expected values from an arithmetic reference model.
module tb_alu_exec_unit;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [7:0] lo;
        logic [7:0] hi;
        logic       c;
        logic       v;
        logic       z;
        logic       dbz;
    } res_t;

    typedef struct {
        res_t r;
        int   cyc;
        int   busy_cycles;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_run = 0;
    exp_t sb[$];

    alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

    alu_exec_unit #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        res_t r;
        int ux, uy, sx, sy, t;
        r  = '0;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        case (o)
            3'd0: begin
                t = ux + uy; r.lo = 8'(t); r.c = (t > 255);
                r.v = (sx + sy > 127) || (sx + sy < -128);
            end
            3'd1: begin
                t = ux - uy; r.lo = 8'(t); r.c = (ux < uy);
                r.v = (sx - sy > 127) || (sx - sy < -128);
            end
            3'd2: r.lo = x & y;
            3'd3: r.lo = x | y;
            3'd4: r.lo = x ^ y;
            3'd5: r.lo = ~x;
            3'd6: begin
                t = ux * uy; r.lo = 8'(t % 256); r.hi = 8'(t / 256);
                r.v = (r.hi != 8'd0);
            end
            default: begin
                if (uy == 0) begin
                    r.lo = 8'hFF; r.hi = x; r.dbz = 1'b1;
                end else begin
                    r.lo = 8'(ux / uy); r.hi = 8'(ux % uy);
                end
            end
        endcase
        if (o == 3'd6)                     r.z = (ux * uy == 0);
        else if (o == 3'd7 && uy == 0)     r.z = 1'b0;
        else                               r.z = (r.lo == 8'd0);
        return r;
    endfunction

    // Call at a negedge; returns one negedge later with start dropped.
    task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        int   guard = 0;
        int   lat;
        exp_t e;
        while (bus.busy === 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 100) begin
                checks++;
                errors++;
                $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", guard);
                break;
            end
        end
        lat = ((o == 3'd6) || (o == 3'd7 && y != 8'd0)) ? WIDTH : 0;
        e.r = model(o, x, y);
        e.cyc = cyc + 1 + lat;
        e.busy_cycles = lat;
        sb.push_back(e);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_lo"}, 32'(bus.result_lo), 32'd0);
        check({tag, "_hi"}, 32'(bus.result_hi), 32'd0);
        check({tag, "_flags"}, 32'({bus.carry, bus.overflow, bus.zero, bus.div_by_zero}), 32'd0);
        check({tag, "_busy_done"}, 32'({bus.busy, bus.done}), 32'd0);
    endtask

    // Monitor: every done pulse consumes one expectation.
    always @(negedge clk) begin
        if (reset) begin
            busy_run = 0;
        end else begin
            if (bus.busy) busy_run++;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_lo", 32'(bus.result_lo), 32'(e.r.lo));
                    check("result_hi", 32'(bus.result_hi), 32'(e.r.hi));
                    check("flags_cvzd", 32'({bus.carry, bus.overflow, bus.zero, bus.div_by_zero}),
                          32'({e.r.c, e.r.v, e.r.z, e.r.dbz}));
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                    check("busy_cycles", 32'(busy_run), 32'(e.busy_cycles));
                    check("busy_at_done", 32'(bus.busy), 32'd0);
                end
                busy_run = 0;
            end
        end
    end

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = 8'd0;
        bus.b     = 8'd0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        issue(3'd0, 8'hFF, 8'h01);
        issue(3'd1, 8'h80, 8'h01);
        issue(3'd1, 8'h03, 8'h05);

        // MUL with an ignored ADD start and operand churn mid-flight
        issue(3'd6, 8'hFF, 8'hFF);
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 8'h12; bus.b = 8'h34;
        @(negedge clk);
        bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.op = 3'd7;

        issue(3'd7, 8'd200, 8'd7);
        issue(3'd7, 8'h2A, 8'h00);

        // Reset at iteration 4 of a MUL aborts it with no done
        issue(3'd6, 8'h0F, 8'h11);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        sb.delete();
        #1 check_all_zero("abort");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        issue(3'd6, 8'h0F, 8'h11);

        // Back-to-back single-cycle ops with start effectively held
        issue(3'd4, 8'hAA, 8'h55);
        issue(3'd5, 8'h0F, 8'h00);

        for (int i = 0; i < 150; i++) begin
            logic [2:0] o;
            logic [7:0] x, y;
            o = 3'($urandom_range(0, 7));
            x = 8'($urandom);
            y = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            issue(o, x, y);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
